// File: rtl/alu_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops plus iterative unsigned multiply/divide,
// results registered behind a valid/ready handshake.
module alu_mc #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [3:0]   AluOp,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [n-1:0] AluOut,
  output logic         zflag,
  output logic         Busy
);

  localparam int unsigned SW = $clog2(n);
  localparam int unsigned AW = 2 * n;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    opnd_q, opnd_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [n-1:0]    res_q, res_d;
  logic            z_q, z_d;

  logic [n-1:0]    alu_c;
  logic [SW-1:0]   shamt_c;
  logic            iter_c;
  logic [n:0]      mul_sum_c;
  logic [n:0]      div_rem_c;
  logic [n:0]      div_try_c;
  logic [AW-1:0]   acc_step_c;
  logic [n-1:0]    iter_res_c;

  assign shamt_c = B[SW-1:0];
  assign iter_c  = (AluOp == 4'd8) || (AluOp == 4'd11) || (AluOp == 4'd12) || (AluOp == 4'd13);

  // Single-cycle result, computed from the live request operands.
  always_comb begin
    alu_c = '0;
    unique case (AluOp)
      4'd0:    alu_c = A + B;
      4'd1:    alu_c = A - B;
      4'd2:    alu_c = A << shamt_c;
      4'd3:    alu_c = n'($signed(A) < $signed(B));
      4'd4:    alu_c = n'(A < B);
      4'd5:    alu_c = A ^ B;
      4'd6:    alu_c = A >> shamt_c;
      4'd7:    alu_c = $unsigned($signed(A) >>> shamt_c);
      4'd9:    alu_c = A | B;
      4'd10:   alu_c = A & B;
      default: alu_c = '0;
    endcase
  end

  // acc holds {product_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum_c = {1'b0, acc_q[AW-1:n]} + {1'b0, opnd_q};
  assign div_rem_c = {acc_q[AW-1:n], acc_q[n-1]};
  assign div_try_c = div_rem_c - {1'b0, opnd_q};

  always_comb begin
    acc_step_c = acc_q;
    if (op_q[2]) begin
      if (!div_try_c[n]) acc_step_c = {div_try_c[n-1:0], acc_q[n-2:0], 1'b1};
      else               acc_step_c = {div_rem_c[n-1:0], acc_q[n-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_step_c = {mul_sum_c, acc_q[n-1:1]};
      else          acc_step_c = {1'b0, acc_q[AW-1:1]};
    end
  end

  // MULHU/REMU (odd opcodes) take the upper half; MUL/DIVU the lower.
  assign iter_res_c = op_q[0] ? acc_step_c[AW-1:n] : acc_step_c[n-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          op_d = AluOp;
          if (iter_c) begin
            state_d = BUSY;
            cnt_d   = SW'(n - 1);
            opnd_d  = AluOp[2] ? B : A;
            acc_d   = AluOp[2] ? {n'(0), A} : {n'(0), B};
          end else begin
            state_d = DONE;
            res_d   = alu_c;
            z_d     = (alu_c == '0);
          end
        end
      end
      BUSY: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = iter_res_c;
          z_d     = (iter_res_c == '0);
        end
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      z_q     <= z_d;
    end
  end

  assign AluOut   = res_q;
  assign zflag    = z_q;
  assign OutValid = (state_q == DONE);
  assign InReady  = (state_q == IDLE);
  assign Busy     = (state_q == BUSY);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at issue, popped when OutValid rises.
module tb_alu_mc;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         InValid;
  logic         InReady;
  logic [3:0]   AluOp;
  logic [N-1:0] A, B;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] AluOut;
  logic         zflag;
  logic         Busy;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  alu_mc #(.n(N)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .AluOp(AluOp),
    .A(A), .B(B), .OutValid(OutValid), .OutReady(OutReady), .AluOut(AluOut),
    .zflag(zflag), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return p[31:0];
      4'd9:  return a | b;
      4'd10: return a & b;
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op, wait for its result, optionally stall the consumer and poke InValid mid-BUSY.
  task automatic do_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input int hold, input bit poke);
    int lat;
    int busy_n;
    bit iter;
    logic [N-1:0] expv;
    iter = (op == 4'd8) || (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    chk("in_ready_idle", InReady, 1);
    InValid = 1'b1; AluOp = op; A = a; B = b;
    @(posedge clk);
    #1;
    InValid = 1'b0; AluOp = 4'($urandom); A = $urandom; B = $urandom;
    lat = 0;
    busy_n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (Busy) busy_n++;
      if (poke && lat == 3) begin
        InValid = 1'b1; AluOp = 4'd0; A = 32'd1; B = 32'd1;
      end
      if (OutValid) break;
    end
    InValid = 1'b0;
    chk($sformatf("latency_op%0d", op), 64'(lat), iter ? 64'd33 : 64'd1);
    chk($sformatf("busy_cycles_op%0d", op), 64'(busy_n), iter ? 64'd32 : 64'd0);
    expv = exp_q.pop_front();
    chk($sformatf("result_op%0d", op), AluOut, expv);
    chk($sformatf("zflag_op%0d", op), zflag, (expv == 0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_result", AluOut, expv);
      chk("hold_zflag", zflag, (expv == 0));
      chk("hold_valid", OutValid, 1);
      chk("hold_in_ready", InReady, 0);
    end
    OutReady = 1'b1;
    @(negedge clk);
    OutReady = 1'b0;
    chk("consumed_valid", OutValid, 0);
    chk("consumed_in_ready", InReady, 1);
    chk("consumed_busy", Busy, 0);
    if (hold > 0 || poke) chk("result_kept", AluOut, expv);
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; AluOp = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", AluOut, 0);
    chk("rst_z", zflag, 0);
    chk("rst_valid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", InReady, 1);

    do_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op(4'd1, 32'd5, 32'd7, 0, 0);
    do_op(4'd7, 32'h8000_0000, 32'h24, 0, 0);
    do_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(4'd12, 32'd100, 32'd7, 0, 0);
    do_op(4'd13, 32'd100, 32'd7, 0, 0);
    do_op(4'd12, 32'hDEAD_BEEF, 32'd0, 0, 0);
    do_op(4'd13, 32'h1234, 32'd0, 0, 0);
    do_op(4'd2, 32'h0000_0003, 32'hFFFF_FFE4, 10, 0);
    do_op(4'd12, 32'hFFFF_FFFF, 32'h0001_0000, 0, 1);
    do_op(4'd14, 32'h1234, 32'h5678, 0, 0);
    do_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [3:0]   rop;
      logic [N-1:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      do_op(rop, ra, rb, 0, 0);
    end

    do_op(4'd9, 32'h00F0_0F00, 32'h0F00_00F0, 0, 0);

    // Abort a DIVU on its tenth BUSY cycle.
    @(negedge clk);
    InValid = 1'b1; AluOp = 4'd12; A = 32'd1000; B = 32'd3;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", Busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_valid", OutValid, 0);
    chk("abort_out", AluOut, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_z", zflag, 0);
    @(negedge clk);
    reset = 1'b0;
    do_op(4'd0, 32'd2, 32'd3, 0, 0);

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
